// File: rtl/tbuf_drive_sequencer.sv
// Drive sequencer for the pad-side tri-state cluster: group A on lanes 0-2,
// lanes 3/4 share one net with break-before-make turnaround between owners.
module tbuf_drive_sequencer #(
    parameter int DRIVE_CYC = 2,
    parameter int TURN_CYC  = 1
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       a_valid,
    input  logic [2:0] a_data,
    output logic       a_ready,
    input  logic       b3_valid,
    input  logic       b3_data,
    output logic       b3_ready,
    input  logic       b4_valid,
    input  logic       b4_data,
    output logic       b4_ready,
    output logic [4:0] enable,
    output logic [4:0] input_x,
    output logic [1:0] b_owner
);

    localparam int DW = $clog2(DRIVE_CYC) + 1;
    localparam int TW = $clog2(TURN_CYC) + 1;
    localparam logic [DW-1:0] D_LAST = DW'(DRIVE_CYC - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TURN_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TURN_CYC - 1);

    typedef enum logic {A_IDLE, A_DRIVE} a_state_t;
    typedef enum logic [1:0] {B_IDLE, B_TURN, B_DRIVE} b_state_t;

    a_state_t      a_st, a_nxt;
    logic [DW-1:0] a_cnt, a_cnt_nxt;
    logic          a_go;
    logic [2:0]    en_a, x_a;

    b_state_t      b_st, b_nxt;
    logic [DW-1:0] b_cnt, b_cnt_nxt;
    logic [TW-1:0] t_cnt, t_cnt_nxt;
    logic [TW-1:0] idle_cnt, idle_nxt;
    logic [TW:0]   idle_p1;
    logic          last4, own4, has_own, cap_d;
    logic          b_last, arb, win4, b_go, same, idle_ok;
    logic          drv4, drv_d;
    logic [1:0]    en_b, x_b;

    assign enable  = {en_b, en_a};
    assign input_x = {x_b, x_a};

    always_comb begin
        a_nxt     = a_st;
        a_cnt_nxt = a_cnt;
        a_ready   = !RST && (a_st == A_IDLE || a_cnt == '0);
        a_go      = a_valid && a_ready;
        if (a_go) begin
            a_nxt     = A_DRIVE;
            a_cnt_nxt = D_LAST;
        end else if (a_st == A_DRIVE) begin
            if (a_cnt == '0) a_nxt = A_IDLE;
            else a_cnt_nxt = a_cnt - 1'b1;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            a_st  <= A_IDLE;
            a_cnt <= '0;
            en_a  <= 3'b111;
            x_a   <= 3'b000;
        end else begin
            a_st  <= a_nxt;
            a_cnt <= a_cnt_nxt;
            en_a  <= {3{a_nxt != A_DRIVE}};
            if (a_go) x_a <= a_data;
        end
    end

    always_comb begin
        b_nxt     = b_st;
        b_cnt_nxt = b_cnt;
        t_cnt_nxt = t_cnt;
        idle_nxt  = idle_cnt;
        b_last    = (b_st == B_DRIVE) && (b_cnt == '0);
        arb       = !RST && (b_st == B_IDLE || b_last);
        // On a tie the lane that did not win last time gets the grant
        b3_ready  = arb && (!b4_valid || last4);
        b4_ready  = arb && (!b3_valid || !last4);
        win4      = b4_valid && b4_ready;
        b_go      = win4 || (b3_valid && b3_ready);
        same      = has_own && (own4 == win4);
        idle_p1   = {1'b0, idle_cnt} + 1'b1;
        idle_ok   = idle_p1 >= {1'b0, T_MAX};
        drv4      = b_go ? win4 : own4;
        drv_d     = b_go ? (win4 ? b4_data : b3_data) : cap_d;
        unique case (b_st)
            B_IDLE: begin
                if (idle_cnt != T_MAX) idle_nxt = idle_cnt + 1'b1;
                if (b_go) begin
                    if (same || idle_ok) begin
                        b_nxt     = B_DRIVE;
                        b_cnt_nxt = D_LAST;
                    end else begin
                        b_nxt     = B_TURN;
                        t_cnt_nxt = T_LAST - idle_cnt - 1'b1;
                    end
                end
            end
            B_TURN: begin
                if (t_cnt == '0) begin
                    b_nxt     = B_DRIVE;
                    b_cnt_nxt = D_LAST;
                end else begin
                    t_cnt_nxt = t_cnt - 1'b1;
                end
            end
            B_DRIVE: begin
                if (!b_last) begin
                    b_cnt_nxt = b_cnt - 1'b1;
                end else if (b_go && same) begin
                    b_cnt_nxt = D_LAST;
                end else if (b_go) begin
                    b_nxt     = B_TURN;
                    t_cnt_nxt = T_LAST;
                end else begin
                    b_nxt    = B_IDLE;
                    idle_nxt = '0;
                end
            end
            default: b_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            b_st     <= B_IDLE;
            b_cnt    <= '0;
            t_cnt    <= '0;
            idle_cnt <= T_MAX;
            last4    <= 1'b1;
            own4     <= 1'b1;
            has_own  <= 1'b0;
            cap_d    <= 1'b0;
            en_b     <= 2'b11;
            x_b      <= 2'b00;
            b_owner  <= 2'd0;
        end else begin
            b_st     <= b_nxt;
            b_cnt    <= b_cnt_nxt;
            t_cnt    <= t_cnt_nxt;
            idle_cnt <= idle_nxt;
            if (b_go) begin
                last4   <= win4;
                own4    <= win4;
                has_own <= 1'b1;
                cap_d   <= drv_d;
            end
            if (b_nxt == B_DRIVE) begin
                en_b    <= drv4 ? 2'b01 : 2'b10;
                b_owner <= drv4 ? 2'd2 : 2'd1;
                if (drv4) x_b[1] <= drv_d;
                else x_b[0] <= drv_d;
            end else begin
                en_b    <= 2'b11;
                b_owner <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_tbuf_drive_sequencer.sv
// Directed bench for tbuf_drive_sequencer: reset, group A, shared-net
// arbitration/turnaround, streaming and concurrency.
module tb_tbuf_drive_sequencer;

    logic       CK = 1'b0;
    logic       RST;
    logic       a_valid, b3_valid, b3_data, b4_valid, b4_data;
    logic [2:0] a_data;
    logic       a_ready, b3_ready, b4_ready;
    logic [4:0] enable, input_x;
    logic [1:0] b_owner;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_en [8] = '{2'b10, 2'b10, 2'b11, 2'b01,
                               2'b01, 2'b11, 2'b10, 2'b10};
    logic [1:0] exp_ow [8] = '{2'd1, 2'd1, 2'd0, 2'd2,
                               2'd2, 2'd0, 2'd1, 2'd1};
    logic [2:0] dv = 3'b101;

    tbuf_drive_sequencer dut (
        .CK(CK), .RST(RST),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b3_valid(b3_valid), .b3_data(b3_data), .b3_ready(b3_ready),
        .b4_valid(b4_valid), .b4_data(b4_data), .b4_ready(b4_ready),
        .enable(enable), .input_x(input_x), .b_owner(b_owner)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        a_valid = 1'b0; a_data = 3'b000;
        b3_valid = 1'b1; b3_data = 1'b1;
        b4_valid = 1'b1; b4_data = 1'b1;
        tick();
        tick();
        chk("rst_en", 8'(enable), 8'h1f);
        chk("rst_x", 8'(input_x), 8'h00);
        chk("rst_owner", 8'(b_owner), 8'd0);
        chk("rst_rdy", 8'({a_ready, b3_ready, b4_ready}), 8'd0);

        // contention straight out of reset
        @(posedge CK);
        #1;
        RST = 1'b0;
        #1;
        chk("cont_b3_rdy0", 8'(b3_ready), 8'd1);
        chk("cont_b4_rdy0", 8'(b4_ready), 8'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("cont_en43", 8'(enable[4:3]), 8'(exp_en[i]));
            chk("cont_owner", 8'(b_owner), 8'(exp_ow[i]));
        end

        // async reset during lane-3 drive
        #2;
        RST = 1'b1;
        #1;
        chk("arst_en", 8'(enable), 8'h1f);
        chk("arst_x", 8'(input_x), 8'h00);
        chk("arst_owner", 8'(b_owner), 8'd0);
        chk("arst_rdy", 8'({b3_ready, b4_ready}), 8'd0);
        @(posedge CK);
        #1;
        RST = 1'b0;
        b3_valid = 1'b0;
        b4_data = 1'b1;
        #1;
        chk("post_rst_b4_rdy", 8'(b4_ready), 8'd1);
        tick();
        chk("post_rst_en", 8'(enable), 8'b01111);
        chk("post_rst_owner", 8'(b_owner), 8'd2);
        chk("post_rst_x", 8'(input_x), 8'b10000);
        b4_valid = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", 8'(enable), 8'h1f);

        // lane-4 streaming, data 1,0,1
        b4_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b4_data = dv[i];
            #1;
            chk("str_rdy", 8'(b4_ready), 8'd1);
            tick();
            chk("str_en43_a", 8'(enable[4:3]), 8'b01);
            chk("str_owner_a", 8'(b_owner), 8'd2);
            chk("str_x4_a", 8'(input_x[4]), 8'(dv[i]));
            if (i == 2) b4_valid = 1'b0;
            tick();
            chk("str_en43_b", 8'(enable[4:3]), 8'b01);
            chk("str_owner_b", 8'(b_owner), 8'd2);
            chk("str_x4_b", 8'(input_x[4]), 8'(dv[i]));
        end
        tick();
        chk("str_end_en43", 8'(enable[4:3]), 8'b11);
        chk("str_end_owner", 8'(b_owner), 8'd0);

        // lane 3 beat, idle gap, then lane 4 without turnaround
        b3_valid = 1'b1;
        b3_data = 1'b1;
        #1;
        chk("gap_b3_rdy", 8'(b3_ready), 8'd1);
        tick();
        chk("gap_b3_en43", 8'(enable[4:3]), 8'b10);
        chk("gap_b3_owner", 8'(b_owner), 8'd1);
        chk("gap_b3_x3", 8'(input_x[3]), 8'd1);
        b3_valid = 1'b0;
        tick();
        tick();
        chk("gap_idle_en43", 8'(enable[4:3]), 8'b11);
        chk("gap_idle_owner", 8'(b_owner), 8'd0);
        b4_valid = 1'b1;
        b4_data = 1'b0;
        #1;
        chk("gap_b4_rdy", 8'(b4_ready), 8'd1);
        tick();
        chk("gap_b4_en43", 8'(enable[4:3]), 8'b01);
        chk("gap_b4_owner", 8'(b_owner), 8'd2);
        chk("gap_b4_x4", 8'(input_x[4]), 8'd0);
        b4_valid = 1'b0;
        tick();
        tick();

        // group A back-to-back
        a_valid = 1'b1;
        a_data = 3'b101;
        #1;
        chk("ga_rdy0", 8'(a_ready), 8'd1);
        tick();
        chk("ga_en1", 8'(enable), 8'b11000);
        chk("ga_x1", 8'(input_x[2:0]), 8'b101);
        chk("ga_rdy1", 8'(a_ready), 8'd0);
        a_data = 3'b010;
        tick();
        chk("ga_en2", 8'(enable), 8'b11000);
        chk("ga_x2", 8'(input_x[2:0]), 8'b101);
        chk("ga_rdy2", 8'(a_ready), 8'd1);
        tick();
        chk("ga_en3", 8'(enable), 8'b11000);
        chk("ga_x3", 8'(input_x[2:0]), 8'b010);
        chk("ga_rdy3", 8'(a_ready), 8'd0);
        a_valid = 1'b0;
        tick();
        chk("ga_en4", 8'(enable), 8'b11000);
        chk("ga_x4", 8'(input_x[2:0]), 8'b010);
        chk("ga_rdy4", 8'(a_ready), 8'd1);
        tick();
        chk("ga_en5", 8'(enable), 8'h1f);
        chk("ga_x5_hold", 8'(input_x[2:0]), 8'b010);

        // group A and lane 3 accepted on the same edge
        a_valid = 1'b1;
        a_data = 3'b011;
        b3_valid = 1'b1;
        b3_data = 1'b0;
        #1;
        chk("cc_rdy", 8'({a_ready, b3_ready}), 8'b11);
        tick();
        a_valid = 1'b0;
        b3_valid = 1'b0;
        chk("cc_en1", 8'(enable), 8'b10000);
        chk("cc_x1", 8'(input_x), 8'b00011);
        tick();
        chk("cc_en2", 8'(enable), 8'b10000);
        chk("cc_x2", 8'(input_x), 8'b00011);
        tick();
        chk("cc_en3", 8'(enable), 8'h1f);
        chk("cc_x3", 8'(input_x), 8'b00011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
